alu_flags_stage: RTL and testbench
==================================

Name: alu_flags_stage

Overview:
- Registered pipeline stage directly downstream of the ALU add/subtract datapath. It consumes the ALU's 32-bit result, its borrow/carry-out, and the operand sign bits.
- Derives N/Z/C/V condition flags and signed/unsigned compare outcomes from them.
- Presents result and flags to writeback through a valid/ready handshake, using a 2-entry skid buffer so writeback back-pressure never corrupts an in-flight result.
- Keeps a saturating overflow-event counter and a sticky overflow flag for the exception logic.

Parameters:
- WIDTH, 32, datapath width of result; bit WIDTH-1 is the sign bit.
- CNT_W, 8, width of the saturating overflow counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream ALU result valid.
- in_ready  output  1  stage can accept a result this cycle.
- in_op  input  1  0 = add (in_cb is carry-out), 1 = subtract (in_cb is borrow-out).
- in_result  input  WIDTH  ALU result.
- in_cb  input  1  carry-out (add) or borrow-out (subtract).
- in_a_msb  input  1  sign bit of operand A.
- in_b_msb  input  1  sign bit of operand B.
- out_valid  output  1  registered result valid.
- out_ready  input  1  writeback accepts.
- out_result  output  WIDTH  registered result.
- out_n, out_z, out_c, out_v  output  1 each  negative, zero, carry/borrow, signed overflow.
- out_lts  output  1  A < B signed; valid only for subtract, else 0.
- out_ltu  output  1  A < B unsigned; valid only for subtract, else 0.
- ovf_sticky  output  1  set on any accepted result with V=1.
- ovf_count  output  CNT_W  saturating count of accepted results with V=1.
- ovf_clr  input  1  synchronous clear of ovf_sticky and ovf_count.

Behaviour:
- Reset (async, rst_n=0): all of the following go to 0: out_valid, out_result, all flags, out_lts, out_ltu, ovf_sticky, ovf_count, and the skid entry valid/data. in_ready = 1 one cycle after reset deasserts; in_ready = 0 while reset is held.
- Flag derivation, combinational on the input side and registered together with the result. All flags for a result appear on out_* in the same cycle as that result.
  - N = result[WIDTH-1].
  - Z = (result == 0).
  - C = in_cb.
  - Add: V = (a_msb == b_msb) & (r_msb != a_msb).
  - Sub: V = (a_msb != b_msb) & (r_msb != a_msb).
  - Sub only: lts = N ^ V and ltu = in_cb. Both are 0 for add.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Latency is 1 cycle, in to out, when the stage is empty.
  - Throughput is 1 per cycle with out_ready held high.
- Skid buffer states (output reg, skid reg):
  - EMPTY: out_valid=0.
  - ONE: output reg valid, skid empty.
  - FULL: both valid.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + drain -> ONE, with new data loaded into the output reg.
  - ONE + accept, no drain -> FULL, with new data loaded into skid.
  - ONE + drain, no accept -> EMPTY.
  - FULL + drain -> ONE, with skid moved into the output reg.
- in_ready = ~skid_valid and is registered, so there is no combinational path from out_ready to in_ready. In FULL, in_ready = 0.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- While out_valid=1 and out_ready=0, out_result and the flags hold stable.
- Overflow tracking:
  - Updated on input acceptance with V=1: ovf_count increments, saturating at 2^CNT_W-1, and ovf_sticky is set.
  - ovf_clr has priority over a simultaneous increment: the result is count=0 and sticky=0, and that cycle's overflow is discarded.
- Asserting reset mid-operation discards both buffered entries immediately.

Test Plan:
- Sub 5-3, then 3-5, with out_ready=1:
  - 5-3 (in_result=2, in_cb=0) -> out next cycle with N=0, Z=0, C=0, V=0, lts=0, ltu=0.
  - 3-5 (result 0xFFFFFFFE, cb=1) -> N=1, C=1, lts=1, ltu=1.
- Sub 0x80000000 - 1 (result 0x7FFFFFFF, cb=0, a_msb=1, b_msb=0) -> V=1, N=0, lts=1, ltu=0; ovf_count=1, ovf_sticky=1.
- Add 0x7FFFFFFF + 1 (result 0x80000000, cb=0) -> V=1, N=1, lts=0, ltu=0. Add 0xFFFFFFFF + 1 (result 0, cb=1) -> Z=1, C=1, V=0.
- Back-pressure: issue 4 back-to-back inputs with out_ready=0 -> first two accepted, in_ready drops after the 2nd, out_result stays at entry 1; release out_ready -> entries 1-4 emerge in order, none lost.
- Saturation and clear, with CNT_W=2: 5 overflowing results -> ovf_count stays at 3; ovf_clr asserted in the same cycle as a 6th overflow -> count=0, sticky=0.
- Reset mid-flight in the FULL state -> out_valid=0 and ovf_count=0 immediately; first post-reset input appears 1 cycle after acceptance.

Source files
------------

// File: rtl/alu_flags_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_flags_stage
//  Purpose  : Registered stage behind the ALU add/subtract datapath. It
//             derives the N/Z/C/V condition flags and the signed/unsigned
//             less-than outcomes. It passes the result and flags to
//             writeback through a 2-entry skid buffer, and it tracks
//             overflow events with a sticky flag and a saturating counter.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//     clk, rst_n        clock (rising edge), asynchronous active-low reset
//     in_valid/in_ready upstream handshake (in_ready is registered)
//     in_op             0 = add (in_cb is carry), 1 = subtract (in_cb is borrow)
//     in_result         ALU result, WIDTH bits
//     in_cb             carry-out / borrow-out
//     in_a_msb/in_b_msb operand sign bits
//     out_valid/out_ready downstream handshake
//     out_result        registered result
//     out_n/z/c/v       negative, zero, carry/borrow, signed overflow
//     out_lts/out_ltu   A<B signed / unsigned (subtract only, else 0)
//     ovf_sticky        set by any accepted result with V=1
//     ovf_count         saturating count of accepted results with V=1
//     ovf_clr           synchronous clear of ovf_sticky and ovf_count
// ============================================================================
module alu_flags_stage #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_op,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_cb,
   input  logic             in_a_msb,
   input  logic             in_b_msb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_n,
   output logic             out_z,
   output logic             out_c,
   output logic             out_v,
   output logic             out_lts,
   output logic             out_ltu,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] ovf_count,
   input  logic             ovf_clr
);

   // Packed entry layout: {result, n, z, c, v, lts, ltu}
   localparam int               C_PKT_W   = WIDTH + 6;
   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

   // ------------------------------------------------------------------------
   // Flag derivation on the input side
   // ------------------------------------------------------------------------
   logic               w_n;
   logic               w_z;
   logic               w_v;
   logic               w_lts;
   logic               w_ltu;
   logic [C_PKT_W-1:0] w_pkt;
   logic               w_accept;
   logic               w_drain;

   always_comb begin
      w_n = in_result[WIDTH-1];
      w_z = (in_result == '0);
      // Add overflows when like-signed operands give an unlike-signed result.
      // Subtract overflows when unlike-signed operands give a result whose
      // sign differs from A.
      if (in_op) begin
         w_v = (in_a_msb != in_b_msb) && (w_n != in_a_msb);
      end else begin
         w_v = (in_a_msb == in_b_msb) && (w_n != in_a_msb);
      end
      w_lts = in_op & (w_n ^ w_v);
      w_ltu = in_op & in_cb;
      w_pkt = {in_result, w_n, w_z, in_cb, w_v, w_lts, w_ltu};
   end

   // ------------------------------------------------------------------------
   // Skid buffer state
   // ------------------------------------------------------------------------
   logic               out_valid_q,  out_valid_d;
   logic [C_PKT_W-1:0] out_data_q,   out_data_d;
   logic               skid_valid_q, skid_valid_d;
   logic [C_PKT_W-1:0] skid_data_q,  skid_data_d;
   logic               in_ready_q,   in_ready_d;
   logic               ovf_sticky_q, ovf_sticky_d;
   logic [CNT_W-1:0]   ovf_count_q,  ovf_count_d;

   assign w_accept = in_valid & in_ready_q;
   assign w_drain  = out_valid_q & out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;

      case ({out_valid_q, skid_valid_q})
         2'b00: begin
            if (w_accept) begin
               out_valid_d = 1'b1;
               out_data_d  = w_pkt;
            end
         end
         2'b10: begin
            if (w_accept && w_drain) begin
               out_data_d = w_pkt;
            end else if (w_accept) begin
               // Writeback stalled: park the new entry behind the head.
               skid_valid_d = 1'b1;
               skid_data_d  = w_pkt;
            end else if (w_drain) begin
               out_valid_d = 1'b0;
            end
         end
         2'b11: begin
            // in_ready is low here, so only a drain can happen.
            if (w_drain) begin
               out_data_d   = skid_data_q;
               skid_valid_d = 1'b0;
            end
         end
         default: begin
            // A skid entry without a head entry cannot occur. Should it
            // ever appear, promote it so that FIFO order is kept.
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end
      endcase

      // in_ready comes from a register, so out_ready never reaches it
      // combinationally. Taking it from the next skid state keeps it exact.
      in_ready_d = ~skid_valid_d;
   end

   // ------------------------------------------------------------------------
   // Overflow tracking (clear wins over a same-cycle overflow)
   // ------------------------------------------------------------------------
   always_comb begin
      ovf_sticky_d = ovf_sticky_q;
      ovf_count_d  = ovf_count_q;
      if (ovf_clr) begin
         ovf_sticky_d = 1'b0;
         ovf_count_d  = '0;
      end else if (w_accept && w_v) begin
         ovf_sticky_d = 1'b1;
         if (ovf_count_q != C_CNT_MAX) begin
            ovf_count_d = ovf_count_q + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         in_ready_q   <= 1'b0;
         ovf_sticky_q <= 1'b0;
         ovf_count_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         in_ready_q   <= in_ready_d;
         ovf_sticky_q <= ovf_sticky_d;
         ovf_count_q  <= ovf_count_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_result = out_data_q[C_PKT_W-1:6];
   assign out_n      = out_data_q[5];
   assign out_z      = out_data_q[4];
   assign out_c      = out_data_q[3];
   assign out_v      = out_data_q[2];
   assign out_lts    = out_data_q[1];
   assign out_ltu    = out_data_q[0];
   assign ovf_sticky = ovf_sticky_q;
   assign ovf_count  = ovf_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_flags_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_flags_stage
//  Purpose  : Self-checking bench for alu_flags_stage (WIDTH=32, CNT_W=2).
//             Expected entries come from a flag model and are queued when an
//             input is accepted. They are popped and compared when an output
//             transfer takes place.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_flags_stage;

   typedef struct packed {
      logic        op;
      logic [31:0] r;
      logic        cb;
      logic        a;
      logic        b;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_op = 1'b0;
   logic [31:0] in_result = '0;
   logic        in_cb = 1'b0;
   logic        in_a_msb = 1'b0;
   logic        in_b_msb = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_n, out_z, out_c, out_v, out_lts, out_ltu;
   logic        ovf_sticky;
   logic [1:0]  ovf_count;
   logic        ovf_clr = 1'b0;

   int          checks = 0;
   int          failures = 0;
   logic [37:0] sb[$];
   int          exp_cnt = 0;
   logic        exp_sticky = 1'b0;

   alu_flags_stage #(.WIDTH(32), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_result(in_result), .in_cb(in_cb), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_n(out_n), .out_z(out_z), .out_c(out_c), .out_v(out_v),
      .out_lts(out_lts), .out_ltu(out_ltu),
      .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   function automatic logic [37:0] model(vec_t t);
      logic n, z, v, lts, ltu;
      n = t.r[31];
      z = (t.r == 32'd0);
      if (t.op) v = (t.a != t.b) && (n != t.a);
      else      v = (t.a == t.b) && (n != t.a);
      lts = t.op ? (n ^ v) : 1'b0;
      ltu = t.op ? t.cb : 1'b0;
      return {t.r, n, z, t.cb, v, lts, ltu};
   endfunction

   function automatic logic [37:0] actual();
      return {out_result, out_n, out_z, out_c, out_v, out_lts, out_ltu};
   endfunction

   task automatic offer(vec_t t);
      in_valid  = 1'b1;
      in_op     = t.op;
      in_result = t.r;
      in_cb     = t.cb;
      in_a_msb  = t.a;
      in_b_msb  = t.b;
   endtask

   // Advance one clock. The scoreboard and overflow model are updated from
   // the handshake as it stands just before the rising edge.
   task automatic tick();
      logic [37:0] e;
      vec_t        t;
      t = '{in_op, in_result, in_cb, in_a_msb, in_b_msb};
      e = model(t);
      if (rst_n && in_valid && in_ready) sb.push_back(e);
      if (rst_n) begin
         if (ovf_clr) begin
            exp_cnt = 0;
            exp_sticky = 1'b0;
         end else if (in_valid && in_ready && e[2]) begin
            exp_sticky = 1'b1;
            if (exp_cnt < 3) exp_cnt++;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, ovf_sticky, ovf_count} !== 5'b0 || actual() !== 38'd0) begin
         failures++;
         $display("FAIL reset_state: valid=%b ready=%b sticky=%b cnt=%0d data=%h, required all 0",
                  out_valid, in_ready, ovf_sticky, ovf_count, actual());
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
      end
   endtask

   task automatic test_flags();
      vec_t v[5];
      logic [37:0] e;
      v[0] = '{1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0};   // 5-3
      v[1] = '{1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};   // 3-5
      v[2] = '{1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};   // 0x80000000-1
      v[3] = '{1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b0};   // 0x7FFFFFFF+1
      v[4] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};   // 0xFFFFFFFF+1
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (out_valid && out_ready) begin
            checks++;
            e = (sb.size() != 0) ? sb.pop_front() : 38'h0;
            if (actual() !== e) begin
               failures++;
               $display("FAIL flags_out: got %h, required %h", actual(), e);
            end
         end
         if (i == 1) begin
            checks++;
            if (out_valid !== 1'b1) begin
               failures++;
               $display("FAIL flags_latency: out_valid=%b, required 1", out_valid);
            end
         end
         if (i < 5) offer(v[i]);
         else in_valid = 1'b0;
         tick();
         checks++;
         if (ovf_count !== exp_cnt[1:0] || ovf_sticky !== exp_sticky) begin
            failures++;
            $display("FAIL flags_ovf: cnt=%0d sticky=%b, required %0d %b",
                     ovf_count, ovf_sticky, exp_cnt, exp_sticky);
         end
      end
      checks++;
      if (sb.size() != 0 || ovf_count !== 2'd2) begin
         failures++;
         $display("FAIL flags_drain: left=%0d cnt=%0d, required 0 and 2", sb.size(), ovf_count);
      end
   endtask

   task automatic test_backpressure();
      vec_t v[4];
      logic [37:0] e;
      int idx = 0;
      int popped = 0;
      for (int k = 0; k < 4; k++) v[k] = '{1'b0, 32'h1000 + k, 1'b0, 1'b0, 1'b0};
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (idx < 4) offer(v[idx]);
         if (c >= 2) begin
            checks++;
            if (in_ready !== 1'b0) begin
               failures++;
               $display("FAIL bp_ready: cycle %0d in_ready=%b, required 0", c, in_ready);
            end
         end
         if (c >= 1) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== 32'h1000) begin
               failures++;
               $display("FAIL bp_hold: valid=%b result=%h, required 1 00001000", out_valid, out_result);
            end
         end
         if (in_ready) idx++;
         tick();
      end
      checks++;
      if (idx != 2) begin
         failures++;
         $display("FAIL bp_accepted: %0d accepted, required 2", idx);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && (idx < 4 || sb.size() != 0); c++) begin
         if (out_valid && out_ready) begin
            checks++;
            popped++;
            e = (sb.size() != 0) ? sb.pop_front() : 38'h0;
            if (actual() !== e) begin
               failures++;
               $display("FAIL bp_order: got %h, required %h", actual(), e);
            end
         end
         if (idx < 4) offer(v[idx]);
         else in_valid = 1'b0;
         if (in_valid && in_ready) idx++;
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (popped != 4) begin
         failures++;
         $display("FAIL bp_count: %0d emerged, required 4", popped);
      end
   endtask

   task automatic test_back_to_back();
      vec_t t;
      logic [37:0] e;
      int sent = 0;
      for (int c = 0; c < 300 && (sent < 40 || sb.size() != 0); c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (out_valid && out_ready) begin
            checks++;
            e = (sb.size() != 0) ? sb.pop_front() : 38'h0;
            if (actual() !== e) begin
               failures++;
               $display("FAIL b2b_out: got %h, required %h", actual(), e);
            end
         end
         if (sent < 40 && $urandom_range(0, 4) != 0) begin
            t = '{$urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1)};
            if ((sent % 7) == 3) t.r = 32'd0;
            offer(t);
            if (in_ready) sent++;
         end else begin
            in_valid = 1'b0;
         end
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (sb.size() != 0 || sent != 40 || ovf_count !== exp_cnt[1:0]) begin
         failures++;
         $display("FAIL b2b_end: left=%0d sent=%0d cnt=%0d, required 0 40 %0d",
                  sb.size(), sent, ovf_count, exp_cnt);
      end
   endtask

   task automatic test_saturation();
      vec_t t;
      logic [37:0] e;
      t = '{1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
      out_ready = 1'b1;
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      checks++;
      if (ovf_count !== 2'd0 || ovf_sticky !== 1'b0) begin
         failures++;
         $display("FAIL sat_clear0: cnt=%0d sticky=%b, required 0 0", ovf_count, ovf_sticky);
      end
      for (int i = 0; i < 6; i++) begin
         if (out_valid && out_ready) begin
            checks++;
            e = (sb.size() != 0) ? sb.pop_front() : 38'h0;
            if (actual() !== e) begin
               failures++;
               $display("FAIL sat_out: got %h, required %h", actual(), e);
            end
         end
         offer(t);
         ovf_clr = (i == 5);
         tick();
         ovf_clr = 1'b0;
         checks++;
         if (i < 5 && (ovf_count !== ((i < 2) ? i + 1 : 3) || ovf_sticky !== 1'b1)) begin
            failures++;
            $display("FAIL sat_count: step %0d cnt=%0d sticky=%b", i, ovf_count, ovf_sticky);
         end else if (i == 5 && (ovf_count !== 2'd0 || ovf_sticky !== 1'b0)) begin
            failures++;
            $display("FAIL sat_clr_prio: cnt=%0d sticky=%b, required 0 0", ovf_count, ovf_sticky);
         end
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4 && sb.size() != 0; i++) begin
         if (out_valid && out_ready) begin
            checks++;
            e = sb.pop_front();
            if (actual() !== e) begin
               failures++;
               $display("FAIL sat_drain: got %h, required %h", actual(), e);
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_midflight();
      vec_t t;
      logic [37:0] e;
      t = '{1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
      out_ready = 1'b0;
      offer(t);
      tick();
      offer(t);
      tick();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || ovf_count === 2'd0) begin
         failures++;
         $display("FAIL mid_full: ready=%b valid=%b cnt=%0d, required 0 1 nonzero",
                  in_ready, out_valid, ovf_count);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || ovf_count !== 2'd0 || ovf_sticky !== 1'b0 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: valid=%b cnt=%0d sticky=%b ready=%b, required all 0",
                  out_valid, ovf_count, ovf_sticky, in_ready);
      end
      sb.delete();
      exp_cnt = 0;
      exp_sticky = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      out_ready = 1'b1;
      t = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
      offer(t);
      tick();
      in_valid = 1'b0;
      checks++;
      e = (sb.size() != 0) ? sb.pop_front() : 38'h0;
      if (out_valid !== 1'b1 || actual() !== e) begin
         failures++;
         $display("FAIL mid_first: valid=%b got %h, required 1 %h", out_valid, actual(), e);
      end
   endtask

   initial begin
      test_reset();
      test_flags();
      test_backpressure();
      test_back_to_back();
      test_saturation();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
